// File: rtl/pc_next_sel.sv
// Registered fetch PC with an N-source priority redirect selector, stall hold and a
// one-deep pending-redirect buffer that keeps redirects arriving during a stall.
module pc_next_sel #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      NSRC     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      STEP     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic [NSRC-1:0]       redir_valid,
    input  logic [NSRC*WIDTH-1:0] redir_addr,
    output logic [WIDTH-1:0]      pc,
    output logic                  pc_valid,
    output logic                  redir_fire,
    output logic [NSRC-1:0]       redir_src,
    output logic                  pend_valid,
    output logic                  misalign
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             fire_q, fire_d;
    logic [NSRC-1:0]  src_q, src_d;
    logic             mis_q, mis_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [NSRC-1:0]  pend_src_q, pend_src_d;
    logic             pend_mis_q, pend_mis_d;

    logic             any;
    logic [NSRC-1:0]  sel_oh;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_aligned;
    logic             sel_mis;

    // Scan from the lowest priority upward so the lowest valid index is the last to win.
    always_comb begin
        sel_oh   = '0;
        sel_addr = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_addr  = redir_addr[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any         = |redir_valid;
    assign sel_aligned = {sel_addr[WIDTH-1:2], 2'b00};
    assign sel_mis     = |sel_addr[1:0];

    always_comb begin
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        fire_d       = 1'b0;
        src_d        = src_q;
        mis_d        = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_src_d   = pend_src_q;
        pend_mis_d   = pend_mis_q;

        if (!pc_valid_q || stall) begin
            // PC holds; a redirect seen now is parked rather than lost.
            pc_valid_d = 1'b1;
            if (any) begin
                pend_valid_d = 1'b1;
                pend_addr_d  = sel_aligned;
                pend_src_d   = sel_oh;
                pend_mis_d   = sel_mis;
            end
        end else if (any) begin
            pc_d         = sel_aligned;
            fire_d       = 1'b1;
            src_d        = sel_oh;
            mis_d        = sel_mis;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_addr_q;
            fire_d       = 1'b1;
            src_d        = pend_src_q;
            mis_d        = pend_mis_q;
            pend_valid_d = 1'b0;
        end else begin
            pc_d  = pc_q + WIDTH'(STEP);
            src_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pc_valid_q   <= 1'b0;
            fire_q       <= 1'b0;
            src_q        <= '0;
            mis_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_src_q   <= '0;
            pend_mis_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            fire_q       <= fire_d;
            src_q        <= src_d;
            mis_q        <= mis_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_src_q   <= pend_src_d;
            pend_mis_q   <= pend_mis_d;
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign redir_fire = fire_q;
    assign redir_src  = src_q;
    assign pend_valid = pend_valid_q;
    assign misalign   = mis_q;

endmodule

// File: tb/tb_pc_next_sel.sv
// Scoreboard bench for pc_next_sel: a behavioural model pushes expected post-edge state
// when stimulus is driven; the state observed after the edge is popped and compared.
module tb_pc_next_sel;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NSRC  = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  stall;
    logic [NSRC-1:0]       redir_valid;
    logic [NSRC*WIDTH-1:0] redir_addr;
    logic [WIDTH-1:0]      pc;
    logic                  pc_valid;
    logic                  redir_fire;
    logic [NSRC-1:0]       redir_src;
    logic                  pend_valid;
    logic                  misalign;

    pc_next_sel #(
        .WIDTH   (WIDTH),
        .NSRC    (NSRC),
        .RESET_PC(32'h0000_0000),
        .STEP    (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redir_valid(redir_valid),
        .redir_addr (redir_addr),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .redir_fire (redir_fire),
        .redir_src  (redir_src),
        .pend_valid (pend_valid),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        fire;
        logic [3:0]  src;
        logic        pend;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc;
    logic        m_vld, m_fire, m_pend, m_mis, m_pend_mis;
    logic [3:0]  m_src, m_pend_src;
    logic [31:0] m_pend_addr;

    int n_total;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    function automatic logic [127:0] pk(input logic [31:0] a0, input logic [31:0] a1,
                                        input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_vld = 0; m_fire = 0; m_src = 0; m_pend = 0; m_mis = 0;
        m_pend_addr = 0; m_pend_src = 0; m_pend_mis = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic s, input logic [3:0] v, input logic [127:0] a);
        bit          found = 0;
        int          idx = 0;
        logic [31:0] tgt;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && !found) begin
                found = 1;
                idx = i;
            end
        end
        tgt = a[idx*32 +: 32];
        m_fire = 0;
        m_mis  = 0;
        if (!m_vld || s) begin
            m_vld = 1;
            if (found) begin
                m_pend = 1;
                m_pend_addr = tgt & 32'hFFFF_FFFC;
                m_pend_src = 4'b0001 << idx;
                m_pend_mis = (tgt[1:0] != 2'b00);
            end
        end else if (found) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_fire = 1;
            m_src = 4'b0001 << idx;
            m_mis = (tgt[1:0] != 2'b00);
            m_pend = 0;
        end else if (m_pend) begin
            m_pc = m_pend_addr;
            m_fire = 1;
            m_src = m_pend_src;
            m_mis = m_pend_mis;
            m_pend = 0;
        end else begin
            m_pc = m_pc + 32'd4;
            m_src = 0;
        end
    endtask

    // Called just after a falling edge; leaves the bench just after the next falling edge.
    task automatic step(input logic s, input logic [3:0] v, input logic [127:0] a);
        exp_t e;
        stall = s;
        redir_valid = v;
        redir_addr = a;
        model_edge(s, v, a);
        exp_q.push_back('{m_pc, m_vld, m_fire, m_src, m_pend, m_mis});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("pc", pc, e.pc);
            check("pc_valid", {31'd0, pc_valid}, {31'd0, e.vld});
            check("redir_fire", {31'd0, redir_fire}, {31'd0, e.fire});
            check("redir_src", {28'd0, redir_src}, {28'd0, e.src});
            check("pend_valid", {31'd0, pend_valid}, {31'd0, e.pend});
            check("misalign", {31'd0, misalign}, {31'd0, e.mis});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, '0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_pc_valid"}, {31'd0, pc_valid}, 32'd0);
        check({tag, "_redir_fire"}, {31'd0, redir_fire}, 32'd0);
        check({tag, "_redir_src"}, {28'd0, redir_src}, 32'd0);
        check({tag, "_pend_valid"}, {31'd0, pend_valid}, 32'd0);
        check({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redir_valid = '0;
        redir_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Sequential: first edge only validates, then 4, 8, C, 10
        repeat (5) idle();

        // Priority: source 1 beats source 3
        step(1'b0, 4'b1010, pk(32'h0, 32'h100, 32'h0, 32'h200));
        idle();

        // Stall capture on the middle cycle of a 3-cycle stall
        step(1'b1, 4'b0000, '0);
        step(1'b1, 4'b0100, pk(32'h0, 32'h0, 32'h80, 32'h0));
        step(1'b1, 4'b0000, '0);
        idle();
        idle();

        // Supersede a pending entry
        step(1'b1, 4'b0100, pk(32'h0, 32'h0, 32'h80, 32'h0));
        step(1'b0, 4'b1000, pk(32'h0, 32'h0, 32'h0, 32'h300));
        idle();
        idle();

        // Misaligned target and address wrap
        step(1'b0, 4'b0001, pk(32'h1002, 32'h0, 32'h0, 32'h0));
        idle();
        step(1'b0, 4'b0001, pk(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0));
        idle();
        idle();

        // Misaligned redirect parked then applied from pending
        step(1'b1, 4'b0001, pk(32'h2003, 32'h0, 32'h0, 32'h0));
        idle();
        idle();

        // Async reset mid-stall with a pending entry
        step(1'b1, 4'b0100, pk(32'h0, 32'h0, 32'h80, 32'h0));
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle();

        // Redirect on the first post-reset edge is parked, then applied
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'b0010, pk(32'h0, 32'h500, 32'h0, 32'h0));
        idle();
        idle();

        // Mixed traffic
        for (int k = 0; k < 60; k++) begin
            logic [127:0] a;
            for (int j = 0; j < 4; j++) a[j*32 +: 32] = $urandom;
            step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15) & $urandom_range(0, 15)), a);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_next_sel.md
Name: pc_next_sel

Overview:
Parametrised successor to the two-input next-PC select: a registered program counter with an N-source, priority-encoded redirect selector. It adds stall hold and a one-deep pending-redirect buffer, so a redirect that arrives during a stall is kept rather than lost. It sits at the head of the fetch stage, takes redirect requests from the branch, jump and trap logic, and drives the fetch address plus a flush pulse to the pipeline.

Parameters:
WIDTH, 32, PC/address width in bits
NSRC, 4, number of redirect sources; index 0 = highest priority
RESET_PC, 32'h0000_0000, PC value loaded on reset (WIDTH bits)
STEP, 4, sequential increment added to PC each advancing cycle

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC this cycle (fetch/decode back-pressure)
redir_valid  input  NSRC  per-source redirect request
redir_addr  input  NSRC*WIDTH  packed targets; source i occupies bits [i*WIDTH +: WIDTH]
pc  output  WIDTH  current fetch PC (registered)
pc_valid  output  1  PC is valid for fetch
redir_fire  output  1  registered pulse: PC was loaded from a redirect or pending entry last edge (pipeline flush)
redir_src  output  NSRC  registered one-hot source of the last applied redirect; 0 when applied from pending-with-source-cleared (see Behaviour)
pend_valid  output  1  pending-redirect buffer occupied
misalign  output  1  registered pulse: applied target had addr[1:0] != 0

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect mid-cycle):
  - pc=RESET_PC; pc_valid=0; redir_fire=0; redir_src=0; pend_valid=0; misalign=0.
  - Pending buffer contents are discarded.
- First rising edge after rst_n deasserts: pc_valid<=1. PC does not advance on that edge. pc_valid stays 1 until the next reset.
- Selection (combinational): sel = lowest index i with redir_valid[i]=1; any = |redir_valid.
- Per rising edge (pc_valid=1), in priority order:
  1. stall=0, any=1: pc<=target[sel] with bits[1:0] forced to 0; redir_fire<=1; redir_src<=onehot(sel); misalign<=(target[sel][1:0]!=0); pend_valid<=0. An older pending entry is dropped because the new redirect supersedes it.
  2. stall=0, any=0, pend_valid=1: pc<=pend_addr; redir_fire<=1; redir_src<=pend_src; misalign<=pend_mis; pend_valid<=0.
  3. stall=0, any=0, pend_valid=0: pc<=pc+STEP, modulo 2^WIDTH (wraps FFFF_FFFC -> 0000_0000 for STEP=4); redir_fire<=0; redir_src<=0; misalign<=0.
  4. stall=1, any=1: pc holds; capture pend_addr<=aligned target[sel], pend_src<=onehot(sel), pend_mis accordingly; pend_valid<=1. A new capture overwrites any existing pending entry. redir_fire<=0.
  5. stall=1, any=0: pc, pending and pend_valid hold; redir_fire<=0; misalign<=0.
- Redirects on the first post-reset edge (pc_valid still 0) are captured into pending as in case 4, so they are not lost.
- Latency: a redirect presented at cycle n appears on pc after edge n. redir_fire is high during cycle n+1 only.
- pc never holds a value with bits[1:0]!=0 when STEP is a multiple of 4 and RESET_PC is aligned.
- NSRC>=1. The priority encoder must be generic: a loop over NSRC, no hard-coded cases.

Test Plan:
- Reset/sequential: hold rst_n=0 for 3 cycles, release, run 4 cycles with no stall/redirect -> pc_valid=1 after the first edge; pc sequence 0,4,8,C; redir_fire=0 throughout.
- Priority: redir_valid=4'b1010, addr[1]=0x100, addr[3]=0x200 -> next pc=0x100; redir_src=4'b0010; redir_fire pulses exactly 1 cycle; then pc=0x104.
- Stall capture: stall=1 for 3 cycles with redir_valid[2]=1 (0x80) in the 2nd cycle only -> pc frozen; pend_valid=1; on stall release pc=0x80, redir_src=4'b0100, pend_valid=0.
- Supersede: pending holds 0x80; with stall=0 assert redir_valid[3]=1 (0x300) -> pc=0x300; pending cleared; 0x80 never appears on pc.
- Misaligned/wrap: redirect target 0x1002 -> pc=0x1000 and misalign pulses 1 cycle. Redirect to 0xFFFF_FFFC, then advance -> pc=0x0000_0000.
- Async reset mid-stall with pend_valid=1 -> pc=RESET_PC and pend_valid=0 immediately, before the next clock edge; after release no stale redirect is applied.
